// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared widths, funct3 access codes and FSM states for the data-memory responder.
package dmem_responder_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 32;
  localparam int MEM_DEPTH_WORDS = 1024;
  localparam int WAIT_CYCLES = 2;
  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BYTE_U = 3'b100;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
endpackage

// File: rtl/dmem_responder_if.sv
// dmem_responder_if: valid/ready request and response channels between core and data-memory responder.
interface dmem_responder_if import dmem_responder_pkg::*; #(
  parameter int DW = DATA_WIDTH,
  parameter int AW = ADDR_WIDTH
) ();
  logic req_valid_i;
  logic req_ready_o;
  logic req_we_i;
  logic [2:0] req_funct3_i;
  logic [AW-1:0] req_addr_i;
  logic [DW-1:0] req_wdata_i;
  logic rsp_valid_o;
  logic rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic rsp_err_o;
  modport slave (
    input req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
  modport master (
    output req_valid_i, req_we_i, req_funct3_i, req_addr_i, req_wdata_i, rsp_ready_i,
    input req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
  );
endinterface

// File: rtl/dmem_responder_ram.sv
// dmem_ram: single-port synchronous RAM with 4-bit byte-enable write and 1-cycle read (contents not reset).
module dmem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH_WORDS = 1024,
  parameter int IW = $clog2(MEM_DEPTH_WORDS)
) (
  input  logic                  clk_i,
  input  logic                  i_en,
  input  logic [3:0]            i_be,
  input  logic [IW-1:0]         i_idx,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH_WORDS];
  logic [DATA_WIDTH-1:0] r_rdata;
  always_ff @(posedge clk_i)
    if (i_en) begin
      for (int b = 0; b < 4; b++)
        if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      r_rdata <= r_mem[i_idx];
    end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: LB/LW/SB/SW responder with WAIT_CYCLES wait states and in-band errors.
// Define DMEM_UNSIGNED_LOAD_EN to accept funct3 100 (LBU) loads.
module dmem_responder #(
  parameter int DATA_WIDTH = dmem_responder_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = dmem_responder_pkg::ADDR_WIDTH,
  parameter int MEM_DEPTH_WORDS = dmem_responder_pkg::MEM_DEPTH_WORDS,
  parameter int WAIT_CYCLES = dmem_responder_pkg::WAIT_CYCLES
) (
  input logic clk_i,
  input logic rst_ni,
  dmem_responder_if.slave bus
);
  import dmem_responder_pkg::*;
  localparam int IW = $clog2(MEM_DEPTH_WORDS);
  localparam int CW = WAIT_CYCLES > 0 ? $clog2(WAIT_CYCLES + 1) : 1;
  dmem_state_e r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic r_we, r_err, r_rsp_valid, r_rsp_err;
  logic [2:0] r_f3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rsp_rdata;
  logic w_accept, w_exec, w_we, w_lbu_ok, w_err;
  logic [2:0] w_f3;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata, w_ram_q, w_load;
  logic [3:0] w_be;
  logic [7:0] w_byte;
  assign w_accept = bus.req_valid_i && r_state == IDLE;
  // IDLE uses the live request so a zero-wait access executes in its accept cycle.
  assign w_we = r_state == IDLE ? bus.req_we_i : r_we;
  assign w_f3 = r_state == IDLE ? bus.req_funct3_i : r_f3;
  assign w_addr = r_state == IDLE ? bus.req_addr_i : r_addr;
  assign w_wdata = r_state == IDLE ? bus.req_wdata_i : r_wdata;
`ifdef DMEM_UNSIGNED_LOAD_EN
  assign w_lbu_ok = w_f3 == F3_BYTE_U && !w_we;
`else
  assign w_lbu_ok = 1'b0;
`endif
  assign w_err = !(w_f3 == F3_BYTE || w_f3 == F3_WORD || w_lbu_ok)
              || (w_f3 == F3_WORD && w_addr[1:0] != 2'b00)
              || w_addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_DEPTH_WORDS);
  assign w_exec = (WAIT_CYCLES == 0 && w_accept) || (r_state == WAIT && r_cnt == CW'(1));
  assign w_be = !w_we ? 4'b0000 : w_f3 == F3_WORD ? 4'b1111 : 4'b0001 << w_addr[1:0];
  assign w_byte = w_ram_q[8*r_addr[1:0] +: 8];
  assign w_load = r_f3 == F3_WORD ? w_ram_q : {{(DATA_WIDTH-8){r_f3 != F3_BYTE_U && w_byte[7]}}, w_byte};
  dmem_ram #(.DATA_WIDTH(DATA_WIDTH), .MEM_DEPTH_WORDS(MEM_DEPTH_WORDS)) u_ram (
    .clk_i   (clk_i),
    .i_en    (w_exec && !w_err),
    .i_be    (w_be),
    .i_idx   (w_addr[IW+1:2]),
    .i_wdata (w_f3 == F3_WORD ? w_wdata : {(DATA_WIDTH/8){w_wdata[7:0]}}),
    .o_rdata (w_ram_q)
  );
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = !w_accept ? IDLE : WAIT_CYCLES == 0 ? RESP : WAIT;
      WAIT: w_next = r_cnt == CW'(1) ? RESP : WAIT;
      RESP: w_next = r_rsp_valid && bus.rsp_ready_i ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // RESP spends one cycle registering the RAM read before raising rsp_valid_o.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_we <= 1'b0;
      r_err <= 1'b0;
      r_f3 <= '0;
      r_addr <= '0;
      r_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we <= bus.req_we_i;
        r_f3 <= bus.req_funct3_i;
        r_addr <= bus.req_addr_i;
        r_wdata <= bus.req_wdata_i;
        r_err <= w_err;
        r_cnt <= CW'(WAIT_CYCLES);
      end else if (r_state == WAIT) r_cnt <= r_cnt - CW'(1);
      if (r_state == RESP && !r_rsp_valid) begin
        r_rsp_valid <= 1'b1;
        r_rsp_err <= r_err;
        r_rsp_rdata <= r_err || r_we ? '0 : w_load;
      end else if (r_rsp_valid && bus.rsp_ready_i) begin
        r_rsp_valid <= 1'b0;
        r_rsp_err <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  assign bus.req_ready_o = r_state == IDLE;
  assign bus.rsp_valid_o = r_rsp_valid;
  assign bus.rsp_rdata_o = r_rsp_rdata;
  assign bus.rsp_err_o = r_rsp_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed scoreboard bench for a 2-wait-state and a zero-wait responder.
module tb_dmem_responder;
  import dmem_responder_pkg::*;
  typedef struct {logic [31:0] rdata; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dmem_responder_if bus2 ();
  dmem_responder_if bus0 ();
  dmem_responder #(.WAIT_CYCLES(2)) dut  (.clk_i(clk), .rst_ni(rst_n), .bus(bus2));
  dmem_responder #(.WAIT_CYCLES(0)) dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));
  logic v [2], we [2], rr [2], rdy [2], rsv [2], rse [2];
  logic [2:0] f3 [2];
  logic [31:0] a [2], wd [2], rsd [2];
  assign bus2.req_valid_i = v[0];
  assign bus2.req_we_i = we[0];
  assign bus2.req_funct3_i = f3[0];
  assign bus2.req_addr_i = a[0];
  assign bus2.req_wdata_i = wd[0];
  assign bus2.rsp_ready_i = rr[0];
  assign rdy[0] = bus2.req_ready_o;
  assign rsv[0] = bus2.rsp_valid_o;
  assign rsd[0] = bus2.rsp_rdata_o;
  assign rse[0] = bus2.rsp_err_o;
  assign bus0.req_valid_i = v[1];
  assign bus0.req_we_i = we[1];
  assign bus0.req_funct3_i = f3[1];
  assign bus0.req_addr_i = a[1];
  assign bus0.req_wdata_i = wd[1];
  assign bus0.rsp_ready_i = rr[1];
  assign rdy[1] = bus0.req_ready_o;
  assign rsv[1] = bus0.rsp_valid_o;
  assign rsd[1] = bus0.rsp_rdata_o;
  assign rse[1] = bus0.rsp_err_o;
  int passed = 0;
  int total = 0;
  exp_t sb [$];
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
  endtask
  // d selects the instance (0: two wait states, 1: zero wait); hold = cycles of response backpressure.
  task automatic xact(input int d, input bit w, input logic [2:0] fn, input logic [31:0] ad,
                      input logic [31:0] dat, input logic [31:0] er, input bit ee, input int hold);
    exp_t e;
    int n;
    sb.push_back('{rdata: er, err: ee});
    @(negedge clk);
    check("req_ready_idle", 32'(rdy[d]), 1);
    v[d] = 1'b1; we[d] = w; f3[d] = fn; a[d] = ad; wd[d] = dat; rr[d] = (hold == 0);
    @(negedge clk);
    v[d] = 1'b0;
    n = 0;
    while (!rsv[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    check("rsp_valid", 32'(rsv[d]), 1);
    check("rsp_latency", n, d == 0 ? 3 : 1);
    check("rsp_rdata", rsd[d], e.rdata);
    check("rsp_err", 32'(rse[d]), 32'(e.err));
    repeat (hold) begin
      @(negedge clk);
      check("bp_valid", 32'(rsv[d]), 1);
      check("bp_rdata", rsd[d], e.rdata);
      check("bp_req_ready", 32'(rdy[d]), 0);
    end
    rr[d] = 1'b1;
    @(negedge clk);
    check("back_to_idle", 32'(rdy[d]), 1);
    check("rsp_dropped", 32'(rsv[d]), 0);
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; we[i] = 1'b0; rr[i] = 1'b1; f3[i] = 3'b000; a[i] = '0; wd[i] = '0;
    end
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(rsv[0]), 0);
    check("rst_rdata", rsd[0], 0);
    check("rst_err", 32'(rse[0]), 0);
    check("rst_ready", 32'(rdy[0]), 1);
    rst_n = 1'b1;
    xact(0, 1, F3_WORD, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
    xact(0, 0, F3_WORD, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
    xact(0, 1, F3_BYTE, 32'h13, 32'h80, 32'h0, 0, 0);
    xact(0, 0, F3_BYTE, 32'h13, 32'h0, 32'hFFFFFF80, 0, 0);
    xact(0, 0, F3_WORD, 32'h10, 32'h0, 32'h80ADBEEF, 0, 0);
`ifdef DMEM_UNSIGNED_LOAD_EN
    xact(0, 0, F3_BYTE_U, 32'h13, 32'h0, 32'h00000080, 0, 0);
`else
    xact(0, 0, F3_BYTE_U, 32'h13, 32'h0, 32'h0, 1, 0);
`endif
    xact(0, 1, F3_BYTE_U, 32'h13, 32'h55, 32'h0, 1, 0);
    xact(0, 0, F3_WORD, 32'h12, 32'h0, 32'h0, 1, 0);
    xact(0, 1, F3_WORD, 32'h12, 32'h11111111, 32'h0, 1, 0);
    xact(0, 0, F3_WORD, 32'h10, 32'h0, 32'h80ADBEEF, 0, 0);
    xact(0, 0, F3_WORD, 32'h1000, 32'h0, 32'h0, 1, 0);
    xact(0, 0, F3_BYTE, 32'h1000, 32'h0, 32'h0, 1, 0);
    xact(0, 0, 3'b001, 32'h10, 32'h0, 32'h0, 1, 0);
    xact(0, 1, F3_BYTE, 32'hFFC, 32'h5A, 32'h0, 0, 0);
    xact(0, 0, F3_BYTE, 32'hFFC, 32'h0, 32'h0000005A, 0, 0);
    xact(0, 0, F3_WORD, 32'h10, 32'h0, 32'h80ADBEEF, 0, 5);
    xact(0, 1, F3_WORD, 32'h20, 32'hCAFEF00D, 32'h0, 0, 0);
    @(negedge clk);
    v[0] = 1'b1; we[0] = 1'b1; f3[0] = F3_WORD; a[0] = 32'h20; wd[0] = 32'h12345678;
    @(negedge clk);
    v[0] = 1'b0;
    check("mid_op_busy", 32'(rdy[0]), 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(rsv[0]), 0);
    check("mid_rst_rdata", rsd[0], 0);
    check("mid_rst_err", 32'(rse[0]), 0);
    check("mid_rst_ready", 32'(rdy[0]), 1);
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 0, F3_WORD, 32'h20, 32'h0, 32'hCAFEF00D, 0, 0);
    xact(1, 1, F3_WORD, 32'h40, 32'hA5A5A5A5, 32'h0, 0, 0);
    xact(1, 0, F3_BYTE, 32'h41, 32'h0, 32'hFFFFFFA5, 0, 0);
    xact(1, 1, F3_BYTE, 32'h40, 32'h7F, 32'h0, 0, 0);
    xact(1, 0, F3_WORD, 32'h40, 32'h0, 32'hA5A5A57F, 0, 2);
    xact(1, 0, F3_WORD, 32'h42, 32'h0, 32'h0, 1, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Data-memory responder for the multi-cycle core; services the LOAD/STORE accesses whose effective address the ALU computes (LB, LW, SB, SW).
- Sits between the core's memory-access state and on-chip data RAM.
- Valid/ready request channel and valid/ready response channel.
- Programmable wait-state latency to model slow memory; errors reported in-band.

Parameters:
DATA_WIDTH, 32 (params_pkg::DATA_WIDTH), data bus and word width
ADDR_WIDTH, 32, byte address width
MEM_DEPTH_WORDS, 1024, RAM depth in words
WAIT_CYCLES, 2, extra cycles between accept and response (0 allowed)

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; one clock, reset asynchronous and active-low
req_valid_i  in  1  request present
req_ready_o  out  1  responder can accept request
req_we_i  in  1  1 = store, 0 = load
req_funct3_i  in  3  access size: 000 byte, 010 word
req_addr_i  in  ADDR_WIDTH  byte address (ALU result)
req_wdata_i  in  DATA_WIDTH  store data; byte stores use bits [7:0]
rsp_valid_o  out  1  response present
rsp_ready_i  in  1  core consumes response
rsp_rdata_o  out  DATA_WIDTH  load data, already extended; 0 for stores and errors
rsp_err_o  out  1  access faulted

Behaviour:
- FSM: IDLE, WAIT, RESP.
- req_ready_o = (state == IDLE).
- Handshake: request accepted when req_valid_i && req_ready_o. All request fields latched on acceptance.
- IDLE -> WAIT on accept, with wait counter loaded to WAIT_CYCLES. If WAIT_CYCLES = 0, IDLE -> RESP directly.
- WAIT: counter decrements each cycle. At 1, the access executes and the FSM enters RESP next cycle.
- Latency: accept at edge T, rsp_valid_o high after edge T+1+WAIT_CYCLES.
- RESP: rsp_valid_o, rsp_rdata_o and rsp_err_o are registered and held stable until rsp_ready_i is high. RESP -> IDLE on that cycle.
- No new request accepted in the same cycle as the response handshake; the next accept is one cycle later at the earliest.
- Word index = addr[ADDR_WIDTH-1:2]. Byte lane = addr[1:0], little-endian.
- SB writes lane byte only, using byte enable.
- SW writes all four bytes.
- LB sign-extends the selected byte. LW returns the word.
- Memory write happens exactly once, in the execute cycle.
- Error (rsp_err_o = 1, rsp_rdata_o = 0, no RAM write) when any of:
  - word access with addr[1:0] != 0;
  - word index >= MEM_DEPTH_WORDS;
  - unsupported funct3.
- Reset (async assert): state IDLE, counter 0, rsp_valid_o 0, rsp_rdata_o 0, rsp_err_o 0. req_ready_o reads 1 once in IDLE.
- RAM contents are not reset.
- Reset mid-operation abandons the request. A store not yet executed is never written.

Optional Feature:
DMEM_UNSIGNED_LOAD_EN.
- Defined: funct3 100 (LBU) is a legal load that zero-extends the byte. funct3 100 with req_we_i = 1 is an error.
- Undefined: funct3 100 is an error in all cases.

Decomposition:
- params_pkg additions: F3_BYTE = 3'b000, F3_WORD = 3'b010, F3_BYTE_U = 3'b100; typedef enum dmem_state_e {IDLE, WAIT, RESP}.
- One sub-module, dmem_ram:
  - single-port synchronous RAM, MEM_DEPTH_WORDS x DATA_WIDTH;
  - 4-bit byte-enable write, 1-cycle read.
  - The responder issues the RAM read in the execute cycle so registered data is ready in RESP.
- With WAIT_CYCLES = 0, the execute cycle is the accept cycle.

Test Plan:
1. SW addr 0x10, data 0xDEADBEEF; then LW 0x10 -> rsp_rdata_o 0xDEADBEEF, rsp_err_o 0; rsp_valid_o exactly 3 cycles after accept (WAIT_CYCLES = 2).
2. SB addr 0x13, data 0x80; LB 0x13 -> 0xFFFFFF80. LW 0x10 -> 0x80ADBEEF. With DMEM_UNSIGNED_LOAD_EN, LBU 0x13 -> 0x00000080.
3. LW addr 0x12 (misaligned) -> rsp_err_o 1, rdata 0. SW 0x12 followed by LW 0x10 -> word unchanged.
4. LW addr 0x1000 (index 1024, out of range) -> error. funct3 001 -> error. funct3 100 -> error when the macro is undefined.
5. Backpressure: hold rsp_ready_i 0 for 5 cycles -> rsp_valid_o stays 1 and data stable, req_ready_o stays 0. Release -> IDLE next cycle.
6. SW 0x20 data 0x12345678 accepted, rst_ni pulled low during WAIT -> outputs clear immediately. After reset, LW 0x20 returns the pre-existing content, not 0x12345678. Repeat with WAIT_CYCLES = 0 -> latency 1 cycle.
